controller_link: RTL and testbench
==================================

// Module: controller_link
// PURPOSE
//  Multi-channel serial controller link between the console and the controller uC. Successor to
//  the single-lane ControllerClk/ControllerIn/ControllerOut port: N controllers per frame,
//  framed transfers, outbound (rumble/LED) data, timeout and short-frame recovery. Link pins are
//  sampled as data in the Clk domain (oversampled). Sits between the controller pins and Core.
// PARAMETERS
//  CHANNELS     4     controllers carried per frame (1..8)
//  REPORT_BITS  16    inbound button/axis bits per channel
//  OUT_BITS     8     outbound bits per channel; CHANNELS*OUT_BITS <= CHANNELS*REPORT_BITS
//  SYNC_STAGES  2     synchronizer flops on LinkClk/LinkIn/LinkFrame (>=2)
//  TIMEOUT      1024  Clk cycles with no LinkClk edge mid-frame before abort
// PORTS
//  Clk          in   1                     system clock
//  Reset        in   1                     synchronous, active-high
//  LinkClk      in   1                     uC serial clock; async, oversampled
//  LinkFrame    in   1                     frame strobe from uC, high for a whole frame
//  LinkIn       in   1                     serial data from uC, MSB first, channel 0 first
//  LinkOut      out  1                     serial data to uC
//  OutData      in   CHANNELS*OUT_BITS     outbound payload from Core, captured at frame start
//  Reports      out  CHANNELS*REPORT_BITS  last good frame; channel c at [c*REPORT_BITS +: REPORT_BITS]
//  ReportValid  out  1                     one-cycle pulse when Reports updates
//  FrameError   out  1                     one-cycle pulse on aborted/discarded frame
//  ErrorCount   out  8                     saturating count of FrameError pulses
// BEHAVIOUR
//  Reset: Reports=0, ReportValid=0, FrameError=0, ErrorCount=0, LinkOut=0, state IDLE, sync flops 0.
//  Pins pass SYNC_STAGES flops; rise/fall = sync'd LinkClk vs. its previous value (1-cycle pulse).
//  States: IDLE -> SHIFT -> CHECK -> COMMIT -> IDLE; any state -> ABORT -> IDLE.
//  IDLE: on sync'd LinkFrame 0->1: capture OutData into out-shift reg, bit counter=0, LinkOut=MSB,
//    timeout counter=0 -> SHIFT.
//  SHIFT: rise: shift LinkIn into in-shift reg, counter+1, timeout=0. fall: advance out-shift;
//    LinkOut = next bit, 0 once CHANNELS*OUT_BITS bits are sent. counter reaches
//    CHANNELS*REPORT_BITS -> CHECK. Later edges in the same frame are ignored.
//    LinkFrame drops before full count -> ABORT (short frame). timeout reaches TIMEOUT -> ABORT.
//  CHECK: one cycle; parity check when enabled, else -> COMMIT unconditionally.
//  COMMIT: Reports <= in-shift reg, ReportValid=1 for this cycle. Latency: Reports/ReportValid
//    valid 2 Clk cycles after the detected final rise. Then wait for LinkFrame low -> IDLE.
//  ABORT: FrameError=1 for one cycle, ErrorCount+1 saturating at 255, Reports unchanged,
//    LinkOut=0; wait for LinkFrame low -> IDLE.
//  Rise and frame drop in the same cycle: rise is shifted first; if that completes the count,
//    the frame is good. Otherwise -> ABORT.
//  Reset mid-frame: everything returns to reset values; the in-progress frame is discarded.
//  Counters are sized $clog2(CHANNELS*REPORT_BITS+1) and $clog2(TIMEOUT+1); no wrap.
// CONFIGURATION
//  CONTROLLER_LINK_PARITY_EN defined: each channel carries REPORT_BITS+1 bits. The trailing bit
//    is even parity over that channel's bits. CHECK evaluates all channels; any mismatch
//    -> ABORT and no Reports update. Parity bits are not stored in Reports.
//  Undefined: no parity bits; frame length is exactly CHANNELS*REPORT_BITS; CHECK always passes.
// STRUCTURE
//  Package retro_ctrl_pkg: link_state_e enum (IDLE, SHIFT, CHECK, COMMIT, ABORT),
//    ERR_COUNT_W=8, helper function frame_bits(CHANNELS, REPORT_BITS, parity).
//  Sub-module link_sync: SYNC_STAGES synchronizer plus rise/fall detect.
//    One instance per input pin, or one vectored instance.
// TESTING
//  1) CHANNELS=4, REPORT_BITS=16; send 64 bits 0x1234_5678_9ABC_DEF0 with LinkClk period 8 Clk
//     -> Reports=that value, one ReportValid pulse exactly 2 cycles after the last rise.
//  2) OutData=0xA5C3_0F81; run frame -> LinkOut sampled on each rise gives 0xA5C30F81 MSB first,
//     then 0 for the remaining 32 bits.
//  3) Drop LinkFrame after 40 bits -> FrameError pulse, ErrorCount=1, Reports keep prior frame.
//  4) Stop LinkClk after 10 bits for TIMEOUT cycles -> FrameError at TIMEOUT; next frame good.
//  5) Force 260 aborts -> ErrorCount saturates at 255. Assert Reset mid-frame -> all outputs 0.
//  6) With CONTROLLER_LINK_PARITY_EN, corrupt channel 2 parity -> abort, no ReportValid.
//     Good parity -> commit.

Source files
------------

// File: rtl/retro_ctrl_pkg.sv
// retro_ctrl_pkg: shared states, widths and frame-length helper for the controller link
package retro_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, COMMIT, ABORT} link_state_e;

    localparam int ERR_COUNT_W = 8;

    function automatic int frame_bits(input int channels, input int report_bits, input bit parity);
        return channels * (report_bits + (parity ? 1 : 0));
    endfunction

endpackage

// File: rtl/link_sync.sv
// link_sync: multi-flop synchronizer for oversampled link pins with rise/fall pulses
module link_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] stg [STAGES];
    logic [W-1:0] prev;

    // shift pins through the synchronizer chain and keep the last synchronized value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) stg[i] <= '0;
            prev <= '0;
        end else begin
            stg[0] <= din;
            for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
            prev <= stg[STAGES-1];
        end
    end

    assign sync = stg[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/controller_link.sv
// controller_link: framed multi-channel serial link to the controller uC.
// Optional per-channel even parity enabled by defining CONTROLLER_LINK_PARITY_EN.
module controller_link
    import retro_ctrl_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int REPORT_BITS = 16,
    parameter int OUT_BITS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            LinkClk,
    input  logic                            LinkFrame,
    input  logic                            LinkIn,
    output logic                            LinkOut,
    input  logic [CHANNELS*OUT_BITS-1:0]    OutData,
    output logic [CHANNELS*REPORT_BITS-1:0] Reports,
    output logic                            ReportValid,
    output logic                            FrameError,
    output logic [ERR_COUNT_W-1:0]          ErrorCount
);

`ifdef CONTROLLER_LINK_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif
    localparam int CB = REPORT_BITS + int'(PARITY);
    localparam int FB = frame_bits(CHANNELS, REPORT_BITS, PARITY);
    localparam int RW = CHANNELS * REPORT_BITS;
    localparam int OW = CHANNELS * OUT_BITS;
    localparam int CW = $clog2(FB + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    link_state_e     state;
    logic [FB-1:0]   in_sr;
    logic [OW-1:0]   out_sr;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   tmo;
    logic [2:0]      pin_s, pin_r, pin_f;
    logic            unused_edges;
    logic [FB-1:0]   in_nx;
    logic [OW-1:0]   out_nx;
    logic [CW-1:0]   cnt_nx;
    logic [TW-1:0]   tmo_nx;
    logic [RW-1:0]   rep;
    logic            par_ok;
    logic            done;
    logic            timed_out;

    link_sync #(.W(3), .STAGES(SYNC_STAGES)) u_sync (
        .clk  (Clk),
        .rst  (Reset),
        .din  ({LinkIn, LinkFrame, LinkClk}),
        .sync (pin_s),
        .rise (pin_r),
        .fall (pin_f)
    );

    assign unused_edges = ^{pin_f[2:1], pin_r[2]};

    // next-value arithmetic plus unpacking of the received frame (channel 0 arrives first)
    always_comb begin
        in_nx     = (in_sr << 1) | FB'(pin_s[2]);
        out_nx    = out_sr << 1;
        cnt_nx    = cnt + 1'b1;
        tmo_nx    = tmo + 1'b1;
        done      = pin_r[0] && (cnt_nx == CW'(FB));
        timed_out = !pin_r[0] && (tmo_nx == TW'(TIMEOUT));
        rep       = '0;
        for (int c = 0; c < CHANNELS; c++)
            rep[c*REPORT_BITS +: REPORT_BITS] = in_sr[(CHANNELS-1-c)*CB + CB - REPORT_BITS +: REPORT_BITS];
`ifdef CONTROLLER_LINK_PARITY_EN
        par_ok = 1'b1;
        for (int c = 0; c < CHANNELS; c++)
            if (^in_sr[(CHANNELS-1-c)*CB +: CB]) par_ok = 1'b0;
`else
        par_ok = 1'b1;
`endif
    end

    // frame state machine with registered link outputs and status pulses
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            in_sr       <= '0;
            out_sr      <= '0;
            cnt         <= '0;
            tmo         <= '0;
            LinkOut     <= 1'b0;
            Reports     <= '0;
            ReportValid <= 1'b0;
            FrameError  <= 1'b0;
            ErrorCount  <= '0;
        end else begin
            ReportValid <= 1'b0;
            FrameError  <= 1'b0;
            case (state)
                IDLE: if (pin_r[1]) begin
                    out_sr  <= OutData;
                    LinkOut <= OutData[OW-1];
                    in_sr   <= '0;
                    cnt     <= '0;
                    tmo     <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (pin_r[0]) begin
                        in_sr <= in_nx;
                        cnt   <= cnt_nx;
                        tmo   <= '0;
                    end else begin
                        tmo <= tmo_nx;
                    end
                    if (pin_f[0]) begin
                        out_sr  <= out_nx;
                        LinkOut <= out_nx[OW-1];
                    end
                    if (done) begin
                        state <= CHECK;
                    end else if (!pin_s[1] || timed_out) begin
                        state      <= ABORT;
                        FrameError <= 1'b1;
                        ErrorCount <= ErrorCount + ERR_COUNT_W'(ErrorCount != '1);
                        LinkOut    <= 1'b0;
                    end
                end
                CHECK: begin
                    LinkOut <= 1'b0;
                    if (par_ok) begin
                        Reports     <= rep;
                        ReportValid <= 1'b1;
                        state       <= COMMIT;
                    end else begin
                        FrameError <= 1'b1;
                        ErrorCount <= ErrorCount + ERR_COUNT_W'(ErrorCount != '1);
                        state      <= ABORT;
                    end
                end
                COMMIT: if (!pin_s[1]) state <= IDLE;
                ABORT:  if (!pin_s[1]) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_controller_link.sv
// tb_controller_link: randomized frame-level checks of controller_link against a bit-stream model
module tb_controller_link;

    localparam int CH = 4;
    localparam int RB = 16;
    localparam int OB = 8;
    localparam int SS = 2;
    localparam int TO = 1024;
`ifdef CONTROLLER_LINK_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FB = CH * (RB + int'(PAR));

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             LinkClk = 1'b0;
    logic             LinkFrame = 1'b0;
    logic             LinkIn = 1'b0;
    logic [CH*OB-1:0] OutData = '0;
    logic             LinkOut;
    logic [CH*RB-1:0] Reports;
    logic             ReportValid;
    logic             FrameError;
    logic [7:0]       ErrorCount;

    controller_link dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .LinkClk     (LinkClk),
        .LinkFrame   (LinkFrame),
        .LinkIn      (LinkIn),
        .LinkOut     (LinkOut),
        .OutData     (OutData),
        .Reports     (Reports),
        .ReportValid (ReportValid),
        .FrameError  (FrameError),
        .ErrorCount  (ErrorCount)
    );

    always #5 Clk = ~Clk;

    int vec = 0, bad = 0;
    int cyc_no = 0, rise_cyc = 0;
    int rv_n = 0, fe_n = 0, rv_cyc = 0, fe_cyc = 0;
    int err_model = 0;
    logic [RB-1:0]    ch [CH];
    bit               stream [$];
    logic [CH*RB-1:0] exp_rep = '0;
    logic [CH*OB-1:0] exp_out = '0;

    always @(posedge Clk) cyc_no++;

    always @(negedge Clk) begin
        if (ReportValid) begin rv_n++; rv_cyc = cyc_no; end
        if (FrameError)  begin fe_n++; fe_cyc = cyc_no; end
    end

    function automatic void build(input bit bad2);
        bit p;
        stream.delete();
        for (int c = 0; c < CH; c++) begin
            for (int b = RB - 1; b >= 0; b--) stream.push_back(ch[c][b]);
            if (PAR) begin
                p = ^ch[c];
                if (bad2 && c == 2) p = ~p;
                stream.push_back(p);
            end
        end
    endfunction

    function automatic logic [CH*RB-1:0] packed_ch();
        logic [CH*RB-1:0] r;
        for (int c = 0; c < CH; c++) r[c*RB +: RB] = ch[c];
        return r;
    endfunction

    function automatic int sat_model();
        return err_model > 255 ? 255 : err_model;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic start_frame();
        exp_out   = OutData;
        LinkClk   = 1'b0;
        LinkFrame = 1'b1;
        cyc(SS + 3);
    endtask

    task automatic end_frame();
        LinkClk   = 1'b0;
        LinkFrame = 1'b0;
        cyc(SS + 4);
    endtask

    task automatic send_bits(input int n, input int half);
        logic exp_lo;
        for (int i = 0; i < n; i++) begin
            LinkClk = 1'b0;
            LinkIn  = stream[i];
            cyc(half);
            exp_lo = (i < CH * OB) ? exp_out[CH*OB-1-i] : 1'b0;
            vec++;
            if (LinkOut !== exp_lo) begin
                bad++;
                $display("FAIL linkout bit %0d: got %b want %b", i, LinkOut, exp_lo);
            end
            LinkClk  = 1'b1;
            rise_cyc = cyc_no;
            cyc(half);
        end
    endtask

    task automatic run_good(input int half);
        int rv0, fe0;
        build(1'b0);
        rv0 = rv_n;
        fe0 = fe_n;
        start_frame();
        send_bits(FB, half);
        end_frame();
        exp_rep = packed_ch();
        vec++;
        if (Reports !== exp_rep) begin bad++; $display("FAIL reports: got %h want %h", Reports, exp_rep); end
        vec++;
        if (rv_n - rv0 !== 1) begin bad++; $display("FAIL reportvalid pulses: got %0d want 1", rv_n - rv0); end
        vec++;
        if (rv_cyc - rise_cyc !== SS + 2) begin bad++; $display("FAIL reportvalid latency: got %0d want %0d", rv_cyc - rise_cyc, SS + 2); end
        vec++;
        if (fe_n - fe0 !== 0) begin bad++; $display("FAIL good frame error pulses: got %0d want 0", fe_n - fe0); end
        vec++;
        if (ErrorCount !== 8'(sat_model())) begin bad++; $display("FAIL errorcount: got %0d want %0d", ErrorCount, sat_model()); end
    endtask

    task automatic rand_ch();
        for (int c = 0; c < CH; c++) ch[c] = RB'($urandom);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        cyc(3);
        vec++;
        if ({Reports, ReportValid, FrameError, ErrorCount, LinkOut} !== '0) begin
            bad++;
            $display("FAIL reset outputs: reports %h rv %b fe %b ec %0d lo %b want all 0", Reports, ReportValid, FrameError, ErrorCount, LinkOut);
        end
        Reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_known_frame();
        ch[0] = 16'hDEF0; ch[1] = 16'h9ABC; ch[2] = 16'h5678; ch[3] = 16'h1234;
        OutData = CH*OB'($urandom);
        run_good(4);
        vec++;
        if (Reports !== 64'h1234_5678_9ABC_DEF0) begin bad++; $display("FAIL known frame: got %h want 123456789abcdef0", Reports); end
    endtask

    task automatic test_outbound();
        rand_ch();
        OutData = 32'hA5C3_0F81;
        run_good(4);
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 6; k++) begin
            rand_ch();
            OutData = CH*OB'($urandom);
            run_good(int'($urandom_range(3, 6)));
        end
    endtask

    task automatic test_short_frame();
        int rv0, fe0;
        rand_ch();
        build(1'b0);
        rv0 = rv_n;
        fe0 = fe_n;
        start_frame();
        send_bits(40, 4);
        end_frame();
        err_model++;
        vec++;
        if (fe_n - fe0 !== 1) begin bad++; $display("FAIL short frame error pulses: got %0d want 1", fe_n - fe0); end
        vec++;
        if (rv_n - rv0 !== 0) begin bad++; $display("FAIL short frame reportvalid: got %0d want 0", rv_n - rv0); end
        vec++;
        if (Reports !== exp_rep) begin bad++; $display("FAIL short frame reports: got %h want %h", Reports, exp_rep); end
        vec++;
        if (ErrorCount !== 8'(sat_model())) begin bad++; $display("FAIL short frame errorcount: got %0d want %0d", ErrorCount, sat_model()); end
    endtask

    task automatic test_timeout();
        int fe0;
        rand_ch();
        build(1'b0);
        start_frame();
        fe0 = fe_n;
        send_bits(10, 4);
        cyc(TO + 10);
        err_model++;
        vec++;
        if (fe_n - fe0 !== 1) begin bad++; $display("FAIL timeout error pulses: got %0d want 1", fe_n - fe0); end
        vec++;
        if (fe_cyc - rise_cyc !== TO + SS + 1) begin bad++; $display("FAIL timeout latency: got %0d want %0d", fe_cyc - rise_cyc, TO + SS + 1); end
        end_frame();
        vec++;
        if (Reports !== exp_rep) begin bad++; $display("FAIL timeout reports: got %h want %h", Reports, exp_rep); end
        rand_ch();
        OutData = CH*OB'($urandom);
        run_good(4);
    endtask

    task automatic test_saturation();
        int fe0;
        fe0 = fe_n;
        for (int k = 0; k < 260; k++) begin
            LinkFrame = 1'b1;
            cyc(4);
            LinkFrame = 1'b0;
            cyc(5);
            err_model++;
            vec++;
            if (ErrorCount !== 8'(sat_model())) begin bad++; $display("FAIL saturation abort %0d: got %0d want %0d", k, ErrorCount, sat_model()); end
        end
        vec++;
        if (fe_n - fe0 !== 260) begin bad++; $display("FAIL saturation pulses: got %0d want 260", fe_n - fe0); end
    endtask

    task automatic test_reset_mid_frame();
        rand_ch();
        build(1'b0);
        OutData = CH*OB'($urandom) | 32'h8000_0001;
        start_frame();
        send_bits(3, 4);
        Reset     = 1'b1;
        LinkFrame = 1'b0;
        LinkClk   = 1'b0;
        cyc(2);
        vec++;
        if ({Reports, ReportValid, FrameError, ErrorCount, LinkOut} !== '0) begin
            bad++;
            $display("FAIL mid-frame reset outputs: reports %h rv %b fe %b ec %0d lo %b want all 0", Reports, ReportValid, FrameError, ErrorCount, LinkOut);
        end
        cyc(2);
        Reset = 1'b0;
        err_model = 0;
        exp_rep = '0;
        cyc(3);
        vec++;
        if ({Reports, ReportValid, FrameError, ErrorCount, LinkOut} !== '0) begin
            bad++;
            $display("FAIL post-reset outputs: reports %h ec %0d lo %b want all 0", Reports, ErrorCount, LinkOut);
        end
        rand_ch();
        OutData = CH*OB'($urandom);
        run_good(4);
    endtask

`ifdef CONTROLLER_LINK_PARITY_EN
    task automatic test_parity();
        int rv0, fe0;
        rand_ch();
        build(1'b1);
        rv0 = rv_n;
        fe0 = fe_n;
        start_frame();
        send_bits(FB, 4);
        end_frame();
        err_model++;
        vec++;
        if (rv_n - rv0 !== 0) begin bad++; $display("FAIL parity reportvalid: got %0d want 0", rv_n - rv0); end
        vec++;
        if (fe_n - fe0 !== 1) begin bad++; $display("FAIL parity error pulses: got %0d want 1", fe_n - fe0); end
        vec++;
        if (Reports !== exp_rep) begin bad++; $display("FAIL parity reports: got %h want %h", Reports, exp_rep); end
        rand_ch();
        run_good(4);
    endtask
`endif

    initial begin
        test_reset();
        test_known_frame();
        test_outbound();
        test_random_frames();
        test_short_frame();
        test_timeout();
`ifdef CONTROLLER_LINK_PARITY_EN
        test_parity();
`endif
        test_saturation();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
